seq_gen_tx: RTL and testbench

- Serial frame transmitter that drives the single-bit `din` input of the sequence-detector block.
- Each frame is: a fixed sync pattern, then a parallel-loaded payload (MSB first), then an optional even-parity bit, then a fixed idle gap.
- Used as the stimulus source and loop-back partner for the detector on the lab board, so the detector fires on frame headers.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/seq_gen_tx_if.sv | 15 +
 rtl/piso_shift.sv | 28 ++
 rtl/seq_gen_tx.sv | 147 ++++++++++++++
 tb/tb_seq_gen_tx.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator and detector: FSM encoding, default sync pattern.
// The detector imports the same pattern so both ends of the loop-back agree on the header.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam int         DEF_PAT_W = 4;
  localparam logic [3:0] DEF_PAT   = 4'b1101;

  // Width of a down-counter that must hold any of the three phase lengths.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_gen_tx_if.sv
// Request/serial-output bundle between a frame requester (master) and seq_gen_tx (slave).
// start/data_in flow in; dout, dout_valid, busy, done flow back.
interface seq_gen_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              dout;
  logic              dout_valid;
  logic              busy;
  logic              done;

  modport master (output start, data_in, input dout, dout_valid, busy, done);
  modport slave  (input start, data_in, output dout, dout_valid, busy, done);
endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB presented on sout; load wins over shift.
// Zero latency from register to sout; no backpressure, shifts only when told.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pdata,
  output logic         sout
);

  logic [W-1:0] sreg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= pdata;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign sout = sreg[W-1];

endmodule

// File: rtl/seq_gen_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, optional even parity, idle gap.
// First bit one cycle after start is accepted; start is ignored (not queued) unless idle.
module seq_gen_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT       = PAT_W'(DEF_PAT),
  parameter int               DATA_W    = 8,
  parameter bit               PARITY_EN = 1'b1,
  parameter int               GAP       = 2
) (
  input  logic         clk,
  input  logic         clr_n,
  seq_gen_tx_if.slave  bus
);

  localparam int               CW       = cnt_w(PAT_W, DATA_W, GAP);
  localparam int               GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  // The first pattern bit goes out straight from PAT, so the register holds the rest.
  localparam logic [PAT_W-1:0] PAT_PRE  = PAT << 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            last;
  logic            ld, pat_shift, dat_shift;
  logic            pat_sout, dat_sout;
  logic            par_q;
  logic            dout_d, vld_d, busy_d, done_d;
  logic            dout_q, vld_q, busy_q, done_q;

  piso_shift #(.W(PAT_W)) u_pat (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (ld),
    .shift (pat_shift),
    .pdata (PAT_PRE),
    .sout  (pat_sout)
  );

  piso_shift #(.W(DATA_W)) u_dat (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (ld),
    .shift (dat_shift),
    .pdata (bus.data_in),
    .sout  (dat_sout)
  );

  assign last = (cnt == '0);

  // Outputs are computed for the next cycle and registered, so each shift
  // register advances in the same cycle its bit is handed to dout_d.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld        = 1'b0;
    pat_shift = 1'b0;
    dat_shift = 1'b0;
    dout_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (bus.start) begin
          ld        = 1'b1;
          state_nxt = ST_SYNC;
          cnt_nxt   = CW'(PAT_W - 1);
          dout_d    = PAT[PAT_W-1];
        end
      end
      ST_SYNC: begin
        if (last) begin
          state_nxt = ST_DATA;
          cnt_nxt   = CW'(DATA_W - 1);
          dout_d    = dat_sout;
          dat_shift = 1'b1;
        end else begin
          cnt_nxt   = cnt - CW'(1);
          dout_d    = pat_sout;
          pat_shift = 1'b1;
        end
      end
      ST_DATA: begin
        if (!last) begin
          cnt_nxt   = cnt - CW'(1);
          dout_d    = dat_sout;
          dat_shift = 1'b1;
        end else if (PARITY_EN) begin
          state_nxt = ST_PAR;
          cnt_nxt   = '0;
          dout_d    = par_q;
        end else begin
          done_d    = 1'b1;
          state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
          cnt_nxt   = CW'(GAP_LAST);
        end
      end
      ST_PAR: begin
        done_d    = 1'b1;
        state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
        cnt_nxt   = CW'(GAP_LAST);
      end
      ST_GAP: begin
        if (last) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    vld_d  = (state_nxt == ST_SYNC) || (state_nxt == ST_DATA) || (state_nxt == ST_PAR);
    busy_d = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      par_q  <= 1'b0;
      dout_q <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      if (ld) begin
        par_q <= ^bus.data_in;
      end
      dout_q <= dout_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx: default config, no-parity config and zero-gap config side by side.
module tb_seq_gen_tx;

  logic clk;
  logic clr_n;
  int   n_vec;
  int   n_err;

  seq_gen_tx_if #(.DATA_W(8)) if_def ();
  seq_gen_tx_if #(.DATA_W(8)) if_np  ();
  seq_gen_tx_if #(.DATA_W(8)) if_g0  ();

  seq_gen_tx u_def (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (if_def)
  );

  seq_gen_tx #(.PARITY_EN(1'b0)) u_np (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (if_np)
  );

  seq_gen_tx #(.GAP(0)) u_g0 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (if_g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {dout, dout_valid, busy, done} of the selected instance
  function automatic logic [3:0] obs_of(input int s);
    case (s)
      0:       return {if_def.dout, if_def.dout_valid, if_def.busy, if_def.done};
      1:       return {if_np.dout,  if_np.dout_valid,  if_np.busy,  if_np.done};
      default: return {if_g0.dout,  if_g0.dout_valid,  if_g0.busy,  if_g0.done};
    endcase
  endfunction

  task automatic drive(input int s, input logic st, input logic [7:0] d);
    case (s)
      0:       begin if_def.start = st; if_def.data_in = d; end
      1:       begin if_np.start  = st; if_np.data_in  = d; end
      default: begin if_g0.start  = st; if_g0.data_in  = d; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int s, input logic [3:0] exp);
    logic [3:0] obs;
    obs = obs_of(s);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (dut %0d): observed {dout,vld,busy,done}=%b expected %b", tag, s, obs, exp);
    end
  endtask

  // Sends one frame from an idle DUT and checks every cycle through two idle cycles after it.
  // inj > 0 pulses a competing start with data 8'hFF in that frame cycle.
  task automatic run_frame(input string name, input int s, input logic [7:0] d,
                           input logic [15:0] bits, input int n, input int gap, input int inj);
    drive(s, 1'b1, d);
    step();
    drive(s, 1'b0, d);
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s_bit%0d", name, i), s, {bits[n-i], 3'b110});
      if (i == inj) drive(s, 1'b1, 8'hFF);
      else          drive(s, 1'b0, d);
      step();
    end
    chk($sformatf("%s_done", name), s, (gap > 0) ? 4'b0011 : 4'b0001);
    step();
    for (int g = 1; g < gap; g++) begin
      chk($sformatf("%s_gap%0d", name, g), s, 4'b0010);
      step();
    end
    chk($sformatf("%s_idle0", name), s, 4'b0000);
    step();
    chk($sformatf("%s_idle1", name), s, 4'b0000);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr_n = 1'b0;
    drive(0, 1'b1, 8'hA5);
    drive(1, 1'b1, 8'h07);
    drive(2, 1'b1, 8'h3C);

    // Reset held with start asserted: everything stays quiet
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d", i), 0, 4'b0000);
      chk($sformatf("rst%0d", i), 2, 4'b0000);
    end
    drive(0, 1'b0, 8'hA5);
    drive(1, 1'b0, 8'h07);
    clr_n = 1'b1;

    // Zero-gap DUT: start held high across release gives 3C then C3 with one idle done cycle
    step();
    drive(2, 1'b1, 8'hC3);
    for (int i = 1; i <= 13; i++) begin
      logic [12:0] f1;
      f1 = 13'b1101_00111100_0;
      chk($sformatf("b2b_f1_bit%0d", i), 2, {f1[13-i], 3'b110});
      step();
    end
    chk("b2b_sep", 2, 4'b0001);
    step();
    drive(2, 1'b0, 8'hC3);
    for (int i = 1; i <= 13; i++) begin
      logic [12:0] f2;
      f2 = 13'b1101_11000011_0;
      chk($sformatf("b2b_f2_bit%0d", i), 2, {f2[13-i], 3'b110});
      step();
    end
    chk("b2b_f2_done", 2, 4'b0001);
    step();
    chk("b2b_idle", 2, 4'b0000);

    // Default DUT frames
    run_frame("a5",     0, 8'hA5, 16'(13'b1101_10100101_0), 13, 2, 0);
    run_frame("ignore", 0, 8'hA5, 16'(13'b1101_10100101_0), 13, 2, 5);
    run_frame("p07",    0, 8'h07, 16'(13'b1101_00000111_1), 13, 2, 0);
    run_frame("np07",   1, 8'h07, 16'(12'b1101_00000111),   12, 2, 0);

    // Mid-frame abort during the fourth payload bit of 8'h5A
    drive(0, 1'b1, 8'h5A);
    step();
    drive(0, 1'b0, 8'h5A);
    repeat (7) step();
    chk("abort_pre", 0, 4'b1110);
    #2;
    clr_n = 1'b0;
    #1;
    chk("abort_async", 0, 4'b0000);
    step();
    chk("abort_nodone", 0, 4'b0000);
    clr_n = 1'b1;
    step();
    chk("abort_idle", 0, 4'b0000);
    run_frame("c1", 0, 8'hC1, 16'(13'b1101_11000001_1), 13, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
